pipelined_lane_adder: RTL and testbench



---
 rtl/pipelined_lane_adder_pkg.sv | 21 ++
 rtl/pipelined_lane_adder_lane.sv | 24 ++
 rtl/pipelined_lane_adder.sv | 84 ++++++++
 tb/tb_pipelined_lane_adder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_lane_adder_pkg.sv
// Shared definitions for the multi-lane pipelined adder: lane slice offsets,
// the default-width lane sum type and its saturation constant.
package pipelined_lane_adder_pkg;

   localparam int DEF_WIDTH = 4;

   typedef logic [DEF_WIDTH:0] lane_sum_t;

   localparam logic [DEF_WIDTH-1:0] SAT_MAX = '1;

   // Bit offset of lane k inside a packed operand bus of w-bit lanes.
   function automatic int op_off(int k, int w);
      return k * w;
   endfunction

   // Bit offset of lane k inside the packed sum bus (w+1 bits per lane).
   function automatic int sum_off(int k, int w);
      return k * (w + 1);
   endfunction

endpackage

// File: rtl/pipelined_lane_adder_lane.sv
// One combinational lane: WIDTH-bit unsigned add with carry out.
// PIPELINED_LANE_ADDER_SATURATE_EN clamps the sum to WIDTH bits; carry stays raw.
module lane_adder #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH:0]   sum,
   output logic             carry
);

   logic [WIDTH:0] raw;

   always_comb begin
      raw   = {1'b0, a} + {1'b0, b};
      carry = raw[WIDTH];
`ifdef PIPELINED_LANE_ADDER_SATURATE_EN
      sum   = raw[WIDTH] ? {1'b0, {WIDTH{1'b1}}} : {1'b0, raw[WIDTH-1:0]};
`else
      sum   = raw;
`endif
   end

endmodule

// File: rtl/pipelined_lane_adder.sv
// LANES independent adders feeding a STAGES-deep valid/ready pipeline with full
// back-pressure. Optional clamping via PIPELINED_LANE_ADDER_SATURATE_EN.
module pipelined_lane_adder
   import pipelined_lane_adder_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int LANES  = 2,
   parameter int STAGES = 2
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LANES*WIDTH-1:0]   in_a,
   input  logic [LANES*WIDTH-1:0]   in_b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LANES*(WIDTH+1)-1:0] out_sum,
   output logic [LANES-1:0]         out_carry
);

   localparam int SW = WIDTH + 1;
   localparam int DW = LANES * SW + LANES;

   logic [LANES*SW-1:0] add_sum;
   logic [LANES-1:0]    add_carry;

   generate
      for (genvar k = 0; k < LANES; k++) begin : g_lane
         lane_adder #(.WIDTH(WIDTH)) u_lane (
            .a     (in_a[op_off(k, WIDTH) +: WIDTH]),
            .b     (in_b[op_off(k, WIDTH) +: WIDTH]),
            .sum   (add_sum[sum_off(k, WIDTH) +: SW]),
            .carry (add_carry[k])
         );
      end
   endgenerate

   logic [STAGES-1:0]         vld_q, vld_d, adv;
   logic [STAGES-1:0][DW-1:0] dat_q, dat_d;
   logic                      full;

   // A stage may advance unless it and every stage downstream of it is full
   // while the consumer stalls; flattened to avoid a chained comb loop.
   always_comb begin
      adv  = '0;
      full = 1'b1;
      for (int i = 0; i < STAGES; i++) begin
         full = 1'b1;
         for (int j = i; j < STAGES; j++) full = full & vld_q[j];
         adv[i] = out_ready | ~full;
      end
   end

   always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      if (adv[0]) begin
         vld_d[0] = in_valid;
         if (in_valid) dat_d[0] = {add_carry, add_sum};
      end
      for (int i = 1; i < STAGES; i++) begin
         if (adv[i]) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vld_q <= '0;
         dat_q <= '0;
      end else begin
         vld_q <= vld_d;
         dat_q <= dat_d;
      end
   end

   assign in_ready               = adv[0];
   assign out_valid              = vld_q[STAGES-1];
   assign {out_carry, out_sum}   = dat_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_lane_adder.sv
// Scoreboard bench: driver pushes model results on input transfer, a monitor
// pops and compares on output transfer. Also sweeps a WIDTH=1/LANES=1/STAGES=1 copy.
module tb_pipelined_lane_adder;

   localparam int W = 4;
   localparam int L = 2;
   localparam int S = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic               in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
   logic [L*W-1:0]     in_a = '0, in_b = '0;
   logic [L*(W+1)-1:0] out_sum;
   logic [L-1:0]       out_carry;

   logic       s_valid = 1'b0, s_ready, s_ov;
   logic [0:0] s_a = '0, s_b = '0;
   logic [1:0] s_sum;
   logic [0:0] s_carry;

   pipelined_lane_adder #(.WIDTH(W), .LANES(L), .STAGES(S)) dut (
      .clock(clk), .reset_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_carry(out_carry)
   );

   pipelined_lane_adder #(.WIDTH(1), .LANES(1), .STAGES(1)) dut_s (
      .clock(clk), .reset_n(rst_n), .in_valid(s_valid), .in_ready(s_ready),
      .in_a(s_a), .in_b(s_b), .out_valid(s_ov), .out_ready(1'b1),
      .out_sum(s_sum), .out_carry(s_carry)
   );

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [L*(W+1)-1:0] sum;
      logic [L-1:0]       carry;
   } exp_t;
   exp_t q[$];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Reference: each lane is an integer sum; overflow is anything beyond 2^W-1.
   function automatic exp_t model(logic [L*W-1:0] a, logic [L*W-1:0] b);
      exp_t e;
      int unsigned x, y, s;
      e = '0;
      for (int k = 0; k < L; k++) begin
         x = int'(a[k*W +: W]);
         y = int'(b[k*W +: W]);
         s = x + y;
         e.carry[k] = (s >= (1 << W));
`ifdef PIPELINED_LANE_ADDER_SATURATE_EN
         if (s > (1 << W) - 1) s = (1 << W) - 1;
`endif
         e.sum[k*(W+1) +: W+1] = (W+1)'(s);
      end
      return e;
   endfunction

   always @(negedge clk)
      if (rst_n && in_valid && in_ready) q.push_back(model(in_a, in_b));

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && out_valid && out_ready) begin
         if (q.size() == 0) begin
            chk("sb_spurious_output", 32'(out_sum), 32'hFFFF_FFFF);
         end else begin
            e = q.pop_front();
            chk("sb_sum", 32'(out_sum), 32'(e.sum));
            chk("sb_carry", 32'(out_carry), 32'(e.carry));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx;
      logic pend;
      logic stall_prev;
      logic [L*(W+1)-1:0] prev_sum;
      logic [2:0] pat;

      // Reset held then released
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_sum", 32'(out_sum), 32'd0);
      chk("rst_out_carry", 32'(out_carry), 32'd0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      chk("pre_beat_out_valid", 32'(out_valid), 32'd0);

      // Basic beat (3,3)+(4,4) with latency 2
      tick();
      in_valid = 1'b1; in_a = {4'd3, 4'd3}; in_b = {4'd4, 4'd4};
      @(negedge clk);
      chk("lat_c0_out_valid", 32'(out_valid), 32'd0);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("lat_c1_out_valid", 32'(out_valid), 32'd0);
      tick();
      @(negedge clk);
      chk("lat_c2_out_valid", 32'(out_valid), 32'd1);
      chk("basic_sum", 32'(out_sum), 32'({5'd7, 5'd7}));
      chk("basic_carry", 32'(out_carry), 32'd0);

      // Overflow 15+1 in both lanes
      tick();
      in_valid = 1'b1; in_a = {4'd15, 4'd15}; in_b = {4'd1, 4'd1};
      tick();
      in_valid = 1'b0;
      tick();
      @(negedge clk);
      chk("ovf_out_valid", 32'(out_valid), 32'd1);
`ifdef PIPELINED_LANE_ADDER_SATURATE_EN
      chk("ovf_sum_sat", 32'(out_sum), 32'({5'h0F, 5'h0F}));
`else
      chk("ovf_sum", 32'(out_sum), 32'({5'h10, 5'h10}));
`endif
      chk("ovf_carry", 32'(out_carry), 32'b11);

      // Back-pressure: stream 0+1, 0+2, 0+3 with consumer stalled
      tick();
      out_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 6; c++) begin
         if (c > 0) tick();
         in_valid = (idx < 3);
         in_a = '0;
         in_b = {4'(idx + 1), 4'(idx + 1)};
         @(negedge clk);
         if (out_valid) chk("stall_sum_hold", 32'(out_sum), 32'({5'd1, 5'd1}));
         if (in_valid && in_ready) idx++;
      end
      chk("stall_accepts", 32'(idx), 32'd2);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      tick();
      out_ready = 1'b1;
      in_valid = 1'b1; in_b = {4'd3, 4'd3};
      @(negedge clk);
      chk("release_in_ready", 32'(in_ready), 32'd1);
      chk("release_out0_valid", 32'(out_valid), 32'd1);
      chk("release_out0_sum", 32'(out_sum), 32'({5'd1, 5'd1}));
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("release_out1_sum", 32'(out_sum), 32'({5'd2, 5'd2}));
      chk("release_out1_valid", 32'(out_valid), 32'd1);
      tick();
      @(negedge clk);
      chk("release_out2_sum", 32'(out_sum), 32'({5'd3, 5'd3}));
      chk("release_out2_valid", 32'(out_valid), 32'd1);

      // Throughput: 16 back-to-back beats of i+i
      for (int t = 0; t < 18; t++) begin
         tick();
         in_valid = (t < 16);
         in_a = {4'(t), 4'(t)};
         in_b = {4'(t), 4'(t)};
         @(negedge clk);
         if (t < 16) chk("tput_in_ready", 32'(in_ready), 32'd1);
         if (t >= 2) chk("tput_out_valid", 32'(out_valid), 32'd1);
      end
      tick();
      in_valid = 1'b0;

      // Randomised traffic with random back-pressure
      pend = 1'b0;
      stall_prev = 1'b0;
      prev_sum = '0;
      for (int n = 0; n < 300; n++) begin
         tick();
         out_ready = ($urandom_range(0, 9) < 6);
         if (!pend) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_a = (L*W)'($urandom);
            in_b = (L*W)'($urandom);
         end
         @(negedge clk);
         if (stall_prev) chk("rand_stall_stable", 32'(out_sum), 32'(prev_sum));
         pend = in_valid && !in_ready;
         stall_prev = out_valid && !out_ready;
         prev_sum = out_sum;
      end
      tick();
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int n = 0; n < 20 && q.size() != 0; n++) @(negedge clk);
      chk("rand_drained", 32'(q.size()), 32'd0);

      // Reset mid-stream with two beats in flight
      tick();
      in_valid = 1'b1; in_a = {4'd1, 4'd1}; in_b = {4'd1, 4'd1};
      tick();
      in_a = {4'd2, 4'd2};
      tick();
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_out_sum", 32'(out_sum), 32'd0);
      q.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("midrst_no_stale", 32'(out_valid), 32'd0);
      end
      tick();
      in_valid = 1'b1; in_a = {4'd5, 4'd5}; in_b = {4'd6, 4'd6};
      tick();
      in_valid = 1'b0;
      tick();
      @(negedge clk);
      chk("midrst_new_valid", 32'(out_valid), 32'd1);
      chk("midrst_new_sum", 32'(out_sum), 32'({5'd11, 5'd11}));

      // Minimal configuration: 1+1 with bubble pattern 1,0,1
      pat = 3'b101;
      for (int t = 0; t < 5; t++) begin
         tick();
         s_valid = (t < 3) ? pat[t] : 1'b0;
         s_a = 1'b1;
         s_b = 1'b1;
         @(negedge clk);
         if (t >= 1 && t <= 3) chk("sweep_out_valid", 32'(s_ov), 32'(pat[t-1]));
         if (s_ov) begin
`ifdef PIPELINED_LANE_ADDER_SATURATE_EN
            chk("sweep_sum", 32'(s_sum), 32'b01);
`else
            chk("sweep_sum", 32'(s_sum), 32'b10);
`endif
            chk("sweep_carry", 32'(s_carry), 32'd1);
         end
      end

      tick();
      chk("final_queue_empty", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
